// File: rtl/frac_clkdiv_prog.sv
// Runtime-programmable fractional clock divider (first-order phase accumulator).
// Emits a one-cycle tick at mean rate f_clk*den/num. A new ratio is taken through
// a valid/ready handshake and is applied only on a tick boundary.
// Optional feature macro: FRAC_DIV_CLKOUT_EN builds the divided square-wave flop
// behind clk_out. When it is undefined, clk_out is tied low.
module frac_clkdiv_prog #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned INIT_NUM = 3,
   parameter int unsigned INIT_DEN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_num,
   input  logic [WIDTH-1:0] cfg_den,
   output logic             cfg_err,
   output logic             tick,
   output logic             active,
   output logic             clk_out
);

   localparam int unsigned AW = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam state_t RST_STATE = (INIT_DEN == 0) ? IDLE : RUN;

   state_t           state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] num_q, num_d;
   logic [WIDTH-1:0] den_q, den_d;
   logic [WIDTH-1:0] sh_num_q, sh_num_d;
   logic [WIDTH-1:0] sh_den_q, sh_den_d;
   logic             tick_q, tick_d;
   logic             cfg_err_q, cfg_err_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             active_q, active_d;

   logic [AW-1:0]    sum;
   logic             wrap;
   logic             xfer;
   logic             bad_cfg;

   // Phase step: acc < num and den <= num, so the extra bit absorbs the carry
   assign sum     = acc_q + AW'(den_q);
   assign wrap    = (sum >= AW'(num_q));
   assign xfer    = cfg_valid && cfg_ready_q;
   assign bad_cfg = (cfg_den == '0) || (cfg_den > cfg_num);

   // Next-state, ratio, accumulator and status decode
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      num_d       = num_q;
      den_d       = den_q;
      sh_num_d    = sh_num_q;
      sh_den_d    = sh_den_q;
      tick_d      = 1'b0;
      cfg_err_d   = xfer && bad_cfg;
      cfg_ready_d = 1'b1;
      active_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (xfer && !bad_cfg) begin
               num_d   = cfg_num;
               den_d   = cfg_den;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (en) begin
               acc_d  = wrap ? (sum - AW'(num_q)) : sum;
               tick_d = wrap;
            end
            if (xfer && !bad_cfg) begin
               sh_num_d = cfg_num;
               sh_den_d = cfg_den;
               state_d  = PEND;
            end
         end
         PEND: begin
            // Swap in the shadow ratio on the tick cycle (or at once when frozen)
            if (!en || tick_q) begin
               num_d   = sh_num_q;
               den_d   = sh_den_q;
               acc_d   = '0;
               state_d = RUN;
            end else begin
               acc_d  = wrap ? (sum - AW'(num_q)) : sum;
               tick_d = wrap;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
         end
      endcase

      cfg_ready_d = (state_d != PEND);
      active_d    = en && (state_d != IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RST_STATE;
         acc_q       <= '0;
         num_q       <= WIDTH'(INIT_NUM);
         den_q       <= WIDTH'(INIT_DEN);
         sh_num_q    <= '0;
         sh_den_q    <= '0;
         tick_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         cfg_ready_q <= 1'b1;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         num_q       <= num_d;
         den_q       <= den_d;
         sh_num_q    <= sh_num_d;
         sh_den_q    <= sh_den_d;
         tick_q      <= tick_d;
         cfg_err_q   <= cfg_err_d;
         cfg_ready_q <= cfg_ready_d;
         active_q    <= active_d;
      end
   end

   assign tick      = tick_q;
   assign cfg_err   = cfg_err_q;
   assign cfg_ready = cfg_ready_q;
   assign active    = active_q;

`ifdef FRAC_DIV_CLKOUT_EN
   logic clk_out_q, clk_out_d;

   // Square wave toggles with every tick; cleared whenever the divider goes idle
   always_comb begin
      clk_out_d = clk_out_q;
      if (state_d == IDLE) begin
         clk_out_d = 1'b0;
      end else if (tick_d) begin
         clk_out_d = ~clk_out_q;
      end
   end

   // Square-wave register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_out_q <= 1'b0;
      end else begin
         clk_out_q <= clk_out_d;
      end
   end

   assign clk_out = clk_out_q;
`else
   assign clk_out = 1'b0;
`endif

endmodule
